// File: rtl/opl3_pkg.sv
// Shared OPL3 types and constants: register-file write bus and host write queue entry.
package opl3_pkg;

    localparam int unsigned REG_FILE_DATA_WIDTH = 8;
    localparam int unsigned HOST_FIFO_DEPTH     = 16;
    localparam int unsigned HOST_WR_SPACING     = 4;

    typedef struct packed {
        logic                           bank_num;
        logic [7:0]                     address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } host_wr_entry_t;

    typedef struct packed {
        logic                           valid;
        logic                           bank_num;
        logic [7:0]                     address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl3_reg_wr_t;

endpackage

// File: rtl/opl3_host_fifo.sv
// Synchronous FIFO with registered read data, registered full/empty and a separate level counter.
module opl3_host_fifo
    import opl3_pkg::*;
#(
    parameter int unsigned DEPTH = HOST_FIFO_DEPTH,
    parameter type entry_t = host_wr_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             rd_data_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, empty_q;
    logic               push_ok, pop_ok;

    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;
    assign level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            level_q <= level_d;
            full_q  <= (level_d == LVL_W'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/opl3_host_if.sv
// Host port front end: latches address/bank, queues data writes and emits
// rate-limited single-cycle register-file write pulses.
module opl3_host_if
    import opl3_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = HOST_FIFO_DEPTH,
    parameter int unsigned WR_SPACING = HOST_WR_SPACING
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        host_wr,
    input  logic [1:0]                  host_addr,
    input  logic [7:0]                  host_data,
    output opl3_reg_wr_t                opl3_reg_wr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        fifo_full,
    output logic                        overflow,
    output logic                        busy
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;

    logic             addr_wr, data_wr, push, pop, fifo_empty;
    logic [7:0]       addr_q;
    logic             bank_q, overflow_q, valid_q, busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] level_next;
    host_wr_entry_t   push_entry, rd_entry;

    assign addr_wr = host_wr & ~host_addr[0];
    assign data_wr = host_wr & host_addr[0];

    // Full is judged on the registered count, so a same-edge pop never rescues a write.
    assign push = data_wr & ~fifo_full;
    assign pop  = ~fifo_empty & (cnt_q == '0);

    assign push_entry = '{bank_num: bank_q, address: addr_q, data: host_data};

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = CNT_W'(WR_SPACING - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            bank_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (addr_wr) begin
                addr_q <= host_data;
                bank_q <= host_addr[1];
            end
            if (data_wr && fifo_full) overflow_q <= 1'b1;
            valid_q <= pop;
            cnt_q   <= cnt_d;
            busy_q  <= (level_next != '0) || (cnt_d != '0);
        end
    end

    opl3_host_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (host_wr_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .rd_data   (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Payload fields hold between pulses because the FIFO read register only loads on pop.
    assign opl3_reg_wr = {valid_q, rd_entry};
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_opl3_host_if.sv
// Directed bench for opl3_host_if: default build, a slow-drain build and a back-to-back build.
module tb_opl3_host_if;
    import opl3_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   hw;
    logic [1:0]   ha;
    logic [7:0]   hd;

    opl3_reg_wr_t rw0, rw1, rw2;
    logic [4:0]   lvl0, lvl1, lvl2;
    logic         full0, full1, full2;
    logic         ovf0, ovf1, ovf2;
    logic         busy0, busy1, busy2;

    always #5 clk = ~clk;

    opl3_host_if u_dut (
        .clk(clk), .reset(reset), .host_wr(hw[0]), .host_addr(ha), .host_data(hd),
        .opl3_reg_wr(rw0), .fifo_level(lvl0), .fifo_full(full0), .overflow(ovf0), .busy(busy0)
    );

    opl3_host_if #(.FIFO_DEPTH(16), .WR_SPACING(64)) u_slow (
        .clk(clk), .reset(reset), .host_wr(hw[1]), .host_addr(ha), .host_data(hd),
        .opl3_reg_wr(rw1), .fifo_level(lvl1), .fifo_full(full1), .overflow(ovf1), .busy(busy1)
    );

    opl3_host_if #(.FIFO_DEPTH(16), .WR_SPACING(1)) u_fast (
        .clk(clk), .reset(reset), .host_wr(hw[2]), .host_addr(ha), .host_data(hd),
        .opl3_reg_wr(rw2), .fifo_level(lvl2), .fifo_full(full2), .overflow(ovf2), .busy(busy2)
    );

    typedef struct {
        int          t;
        logic [16:0] e;
    } ev_t;

    ev_t q0[$], q1[$], q2[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  peak0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write pulse with its cycle stamp, sampled mid-cycle.
    always @(negedge clk) begin
        if (rw0.valid) q0.push_back('{cyc, rw0[16:0]});
        if (rw1.valid) q1.push_back('{cyc, rw1[16:0]});
        if (rw2.valid) q2.push_back('{cyc, rw2[16:0]});
        if (int'(lvl0) > peak0) peak0 = int'(lvl0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int unsigned d, input logic a1, input logic a0, input logic [7:0] v);
        hw    = '0;
        hw[d] = 1'b1;
        ha    = {a1, a0};
        hd    = v;
        @(negedge clk);
        hw = '0;
    endtask

    task automatic idle(input int n);
        hw = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        hw    = '0;
        ha    = '0;
        hd    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_wr",    32'(rw0),   32'h0);
        chk("rst_level", 32'(lvl0),  32'd0);
        chk("rst_full",  32'(full0), 32'd0);
        chk("rst_ovf",   32'(ovf0),  32'd0);
        chk("rst_busy",  32'(busy0), 32'd0);

        // single write latency and busy tail
        wr(0, 1'b0, 1'b0, 8'h20);
        wr(0, 1'b0, 1'b1, 8'h01);
        chk("t1_level_push", 32'(lvl0), 32'd1);
        chk("t1_valid_early", 32'(rw0.valid), 32'd0);
        idle(1);
        chk("t1_pulse", 32'(rw0), 32'h22001);
        chk("t1_level_pop", 32'(lvl0), 32'd0);
        chk("t1_busy_a", 32'(busy0), 32'd1);
        idle(1);
        chk("t1_valid_one", 32'(rw0.valid), 32'd0);
        chk("t1_hold_addr", 32'(rw0.address), 32'h20);
        chk("t1_busy_b", 32'(busy0), 32'd1);
        idle(1);
        chk("t1_busy_c", 32'(busy0), 32'd1);
        idle(1);
        chk("t1_busy_off", 32'(busy0), 32'd0);

        // burst of five with spacing 4
        idle(2);
        q0.delete();
        peak0 = 0;
        wr(0, 1'b1, 1'b0, 8'hB0);
        for (int i = 0; i < 5; i++) wr(0, 1'b0, 1'b1, 8'(16 + i));
        idle(30);
        chk("t2_count", 32'(q0.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < q0.size()) begin
                chk("t2_entry", 32'(q0[i].e), 32'h1B010 + 32'(i));
                if (i > 0) chk("t2_gap", 32'(q0[i].t - q0[i-1].t), 32'd4);
            end
        end
        chk("t2_peak", 32'(peak0), 32'd4);
        chk("t2_full", 32'(full0), 32'd0);

        // overflow while drain is throttled
        q1.delete();
        wr(1, 1'b0, 1'b0, 8'h55);
        wr(1, 1'b0, 1'b1, 8'hE0);
        for (int i = 0; i < 20; i++) wr(1, 1'b0, 1'b1, 8'(i));
        chk("t3_level_full", 32'(lvl1), 32'd16);
        chk("t3_full", 32'(full1), 32'd1);
        chk("t3_ovf", 32'(ovf1), 32'd1);
        idle(1100);
        chk("t3_ovf_sticky", 32'(ovf1), 32'd1);
        chk("t3_full_clear", 32'(full1), 32'd0);
        chk("t3_level_drained", 32'(lvl1), 32'd0);
        chk("t3_count", 32'(q1.size()), 32'd17);
        if (q1.size() > 0) chk("t3_first", 32'(q1[0].e), 32'h055E0);
        for (int i = 0; i < 16; i++) begin
            if (i + 1 < q1.size()) chk("t3_entry", 32'(q1[i+1].e), 32'h05500 + 32'(i));
        end

        // address captured per push
        q0.delete();
        wr(0, 1'b0, 1'b0, 8'h40);
        wr(0, 1'b0, 1'b1, 8'hAA);
        wr(0, 1'b1, 1'b0, 8'h41);
        wr(0, 1'b0, 1'b1, 8'hBB);
        idle(12);
        chk("t4_count", 32'(q0.size()), 32'd2);
        if (q0.size() > 0) chk("t4_e0", 32'(q0[0].e), 32'h040AA);
        if (q0.size() > 1) chk("t4_e1", 32'(q0[1].e), 32'h141BB);

        // reset mid-burst
        wr(0, 1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 11; i++) wr(0, 1'b0, 1'b1, 8'(i + 1));
        chk("t5_level_pre", 32'(lvl0), 32'd8);
        chk("t5_busy_pre", 32'(busy0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_valid", 32'(rw0.valid), 32'd0);
        chk("t5_level", 32'(lvl0), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_ovf_slow", 32'(ovf1), 32'd0);
        q0.delete();
        wr(0, 1'b1, 1'b1, 8'h77);
        idle(10);
        chk("t5_count", 32'(q0.size()), 32'd1);
        if (q0.size() > 0) chk("t5_entry", 32'(q0[0].e), 32'h00077);

        // back-to-back drain with WR_SPACING=1
        q2.delete();
        wr(2, 1'b1, 1'b0, 8'h12);
        wr(2, 1'b0, 1'b1, 8'hC0);
        chk("t6_level_a", 32'(lvl2), 32'd1);
        wr(2, 1'b0, 1'b1, 8'hC1);
        chk("t6_level_b", 32'(lvl2), 32'd1);
        wr(2, 1'b0, 1'b1, 8'hC2);
        chk("t6_level_c", 32'(lvl2), 32'd1);
        idle(1);
        chk("t6_level_d", 32'(lvl2), 32'd0);
        idle(5);
        chk("t6_count", 32'(q2.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q2.size()) begin
                chk("t6_entry", 32'(q2[i].e), 32'h112C0 + 32'(i));
                if (i > 0) chk("t6_gap", 32'(q2[i].t - q2[i-1].t), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
